// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage RISC-V core.
// Latches decoded operands and controls from ID, supports stall (hold) and
// flush (bubble), and drives the EX-side forwarding and ALUSrc muxes.
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int REGW  = 5,
    parameter int CTRLW = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic [XLEN-1:0]  rs1_data_i,
    input  logic [XLEN-1:0]  rs2_data_i,
    input  logic [XLEN-1:0]  imm_i,
    input  logic [REGW-1:0]  rs1_addr_i,
    input  logic [REGW-1:0]  rs2_addr_i,
    input  logic [REGW-1:0]  rd_addr_i,
    input  logic [CTRLW-1:0] alu_ctrl_i,
    input  logic             alu_src_i,
    input  logic             reg_write_i,
    input  logic             mem_read_i,
    input  logic             mem_write_i,
    input  logic             mem_to_reg_i,
    input  logic [1:0]       forward_a_i,
    input  logic [1:0]       forward_b_i,
    input  logic [XLEN-1:0]  ex_mem_data_i,
    input  logic [XLEN-1:0]  mem_wb_data_i,
    output logic [XLEN-1:0]  alu_data1_o,
    output logic [XLEN-1:0]  alu_data2_o,
    output logic [CTRLW-1:0] alu_ctrl_o,
    output logic [XLEN-1:0]  mem_wdata_o,
    output logic [REGW-1:0]  rs1_addr_o,
    output logic [REGW-1:0]  rs2_addr_o,
    output logic [REGW-1:0]  rd_addr_o,
    output logic             reg_write_o,
    output logic             mem_read_o,
    output logic             mem_write_o,
    output logic             mem_to_reg_o,
    output logic             valid_o
);

    logic [XLEN-1:0]  rs1_q, rs2_q, imm_q;
    logic [REGW-1:0]  rs1_addr_q, rs2_addr_q, rd_addr_q;
    logic [CTRLW-1:0] alu_ctrl_q;
    logic             alu_src_q;
    logic             reg_write_q, mem_read_q, mem_write_q, mem_to_reg_q;
    logic             valid_q;
    logic [XLEN-1:0]  fwd_a, fwd_b;

    // Stage register: flush beats stall; a write to x0 is dropped at load time.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i || flush_i) begin
            // Reset and bubble both clear everything, data included.
            rs1_q        <= '0;
            rs2_q        <= '0;
            imm_q        <= '0;
            rs1_addr_q   <= '0;
            rs2_addr_q   <= '0;
            rd_addr_q    <= '0;
            alu_ctrl_q   <= '0;
            alu_src_q    <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            valid_q      <= 1'b0;
        end else if (!stall_i) begin
            rs1_q        <= rs1_data_i;
            rs2_q        <= rs2_data_i;
            imm_q        <= imm_i;
            rs1_addr_q   <= rs1_addr_i;
            rs2_addr_q   <= rs2_addr_i;
            rd_addr_q    <= rd_addr_i;
            alu_ctrl_q   <= alu_ctrl_i;
            alu_src_q    <= alu_src_i;
            reg_write_q  <= reg_write_i && (rd_addr_i != '0);
            mem_read_q   <= mem_read_i;
            mem_write_q  <= mem_write_i;
            mem_to_reg_q <= mem_to_reg_i;
            valid_q      <= 1'b1;
        end
    end

    // Forwarding muxes: 10 = EX/MEM, 01 = MEM/WB, 00/11 = latched register.
    always_comb begin
        fwd_a = rs1_q;
        fwd_b = rs2_q;
        case (forward_a_i)
            2'b10:   fwd_a = ex_mem_data_i;
            2'b01:   fwd_a = mem_wb_data_i;
            default: fwd_a = rs1_q;
        endcase
        case (forward_b_i)
            2'b10:   fwd_b = ex_mem_data_i;
            2'b01:   fwd_b = mem_wb_data_i;
            default: fwd_b = rs2_q;
        endcase
    end

    // Operand 2 takes the immediate for I-type; store data is always forwarded rs2.
    assign alu_data1_o  = fwd_a;
    assign alu_data2_o  = alu_src_q ? imm_q : fwd_b;
    assign mem_wdata_o  = fwd_b;
    assign alu_ctrl_o   = alu_ctrl_q;
    assign rs1_addr_o   = rs1_addr_q;
    assign rs2_addr_o   = rs2_addr_q;
    assign rd_addr_o    = rd_addr_q;
    assign reg_write_o  = reg_write_q;
    assign mem_read_o   = mem_read_q;
    assign mem_write_o  = mem_write_q;
    assign mem_to_reg_o = mem_to_reg_q;
    assign valid_o      = valid_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: a small model of the latched instruction plus
// per-cycle comparison, and directed vectors with literal expectations.
module tb_id_ex_stage;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        stall_i = 1'b0, flush_i = 1'b0;
    logic [31:0] rs1_data_i = '0, rs2_data_i = '0, imm_i = '0;
    logic [4:0]  rs1_addr_i = '0, rs2_addr_i = '0, rd_addr_i = '0;
    logic [3:0]  alu_ctrl_i = '0;
    logic        alu_src_i = 1'b0, reg_write_i = 1'b0, mem_read_i = 1'b0;
    logic        mem_write_i = 1'b0, mem_to_reg_i = 1'b0;
    logic [1:0]  forward_a_i = '0, forward_b_i = '0;
    logic [31:0] ex_mem_data_i = '0, mem_wb_data_i = '0;
    logic [31:0] alu_data1_o, alu_data2_o, mem_wdata_o;
    logic [3:0]  alu_ctrl_o;
    logic [4:0]  rs1_addr_o, rs2_addr_o, rd_addr_o;
    logic        reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o, valid_o;

    int checks = 0;
    int errors = 0;
    bit armed  = 1'b0;

    id_ex_stage dut (
        .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .imm_i(imm_i),
        .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i), .rd_addr_i(rd_addr_i),
        .alu_ctrl_i(alu_ctrl_i), .alu_src_i(alu_src_i), .reg_write_i(reg_write_i),
        .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .mem_to_reg_i(mem_to_reg_i),
        .forward_a_i(forward_a_i), .forward_b_i(forward_b_i),
        .ex_mem_data_i(ex_mem_data_i), .mem_wb_data_i(mem_wb_data_i),
        .alu_data1_o(alu_data1_o), .alu_data2_o(alu_data2_o), .alu_ctrl_o(alu_ctrl_o),
        .mem_wdata_o(mem_wdata_o), .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
        .rd_addr_o(rd_addr_o), .reg_write_o(reg_write_o), .mem_read_o(mem_read_o),
        .mem_write_o(mem_write_o), .mem_to_reg_o(mem_to_reg_o), .valid_o(valid_o)
    );

    always #5 clk_i = ~clk_i;

    // Model: the instruction currently sitting in EX (all-zero means bubble).
    typedef struct packed {
        logic [31:0] rs1, rs2, imm;
        logic [4:0]  a1, a2, rd;
        logic [3:0]  ctrl;
        logic        src, rw, mr, mw, m2r, valid;
    } instr_t;
    instr_t m;

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i)         m <= '0;
        else if (flush_i)  m <= '0;
        else if (!stall_i) m <= '{rs1: rs1_data_i, rs2: rs2_data_i, imm: imm_i,
                                  a1: rs1_addr_i, a2: rs2_addr_i, rd: rd_addr_i,
                                  ctrl: alu_ctrl_i, src: alu_src_i,
                                  rw: reg_write_i && (rd_addr_i != 5'd0),
                                  mr: mem_read_i, mw: mem_write_i, m2r: mem_to_reg_i,
                                  valid: 1'b1};
    end

    function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] own);
        if (sel == 2'b10) return ex_mem_data_i;
        if (sel == 2'b01) return mem_wb_data_i;
        return own;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk_i) begin
        if (armed) begin
            chk("m_data1", alu_data1_o, pick(forward_a_i, m.rs1));
            chk("m_data2", alu_data2_o, m.src ? m.imm : pick(forward_b_i, m.rs2));
            chk("m_wdata", mem_wdata_o, pick(forward_b_i, m.rs2));
            chk("m_ctrl",  {28'd0, alu_ctrl_o}, {28'd0, m.ctrl});
            chk("m_addr",  {17'd0, rs1_addr_o, rs2_addr_o, rd_addr_o}, {17'd0, m.a1, m.a2, m.rd});
            chk("m_ctl",   {27'd0, reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o, valid_o},
                           {27'd0, m.rw, m.mr, m.mw, m.m2r, m.valid});
        end
    end

    task automatic drive(input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im,
                         input logic [3:0] c, input logic s, input logic [4:0] rd,
                         input logic rw, input logic mw);
        rs1_data_i = r1; rs2_data_i = r2; imm_i = im; alu_ctrl_i = c; alu_src_i = s;
        rd_addr_i = rd; reg_write_i = rw; mem_write_i = mw;
        rs1_addr_i = rd + 5'd1; rs2_addr_i = rd + 5'd2;
        mem_read_i = c[0]; mem_to_reg_i = c[1];
    endtask

    task automatic edge1();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #1 rst_i = 1'b1;
        #3;
        chk("rst_valid", {31'd0, valid_o}, 32'd0);
        edge1();
        rst_i = 1'b0;
        armed = 1'b1;

        // Normal SUB load
        drive(32'h5, 32'hFFFF_FFFD, 32'h0, 4'b0100, 1'b0, 5'd3, 1'b1, 1'b0);
        edge1();
        chk("ld_data1", alu_data1_o, 32'h5);
        chk("ld_data2", alu_data2_o, 32'hFFFF_FFFD);
        chk("ld_ctrl",  {28'd0, alu_ctrl_o}, 32'h4);
        chk("ld_valid", {31'd0, valid_o}, 32'd1);

        // Immediate path; rd = x0 must drop the register write
        drive(32'h9, 32'h1234_5678, 32'h2, 4'b0111, 1'b1, 5'd0, 1'b1, 1'b0);
        edge1();
        chk("imm_data2", alu_data2_o, 32'h2);
        chk("imm_wdata", mem_wdata_o, 32'h1234_5678);
        chk("x0_rw",     {31'd0, reg_write_o}, 32'd0);

        // rd = x7, then exercise forwarding within one cycle
        drive(32'h1, 32'h2, 32'h40, 4'b0011, 1'b0, 5'd7, 1'b1, 1'b1);
        edge1();
        chk("x7_rw", {31'd0, reg_write_o}, 32'd1);
        ex_mem_data_i = 32'hAAAA_0000; forward_a_i = 2'b10; #1;
        chk("fwd_exmem", alu_data1_o, 32'hAAAA_0000);
        mem_wb_data_i = 32'h0000_BBBB; forward_a_i = 2'b01; #1;
        chk("fwd_memwb", alu_data1_o, 32'h0000_BBBB);
        forward_a_i = 2'b11; #1;
        chk("fwd_11", alu_data1_o, 32'h1);
        forward_b_i = 2'b10; #0.5;
        chk("fwdb_data2", alu_data2_o, 32'hAAAA_0000);
        chk("fwdb_wdata", mem_wdata_o, 32'hAAAA_0000);
        forward_a_i = 2'b00; forward_b_i = 2'b00;

        // Stall three cycles while ID inputs change
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(32'h99 + i, 32'h77, 32'h55, 4'b0001, 1'b1, 5'd9, 1'b0, 1'b0);
            edge1();
            chk("stall_data1", alu_data1_o, 32'h1);
            chk("stall_ctrl",  {28'd0, alu_ctrl_o}, 32'h3);
            chk("stall_valid", {31'd0, valid_o}, 32'd1);
        end

        // Stall + flush together: flush wins
        flush_i = 1'b1;
        edge1();
        chk("sf_valid", {31'd0, valid_o}, 32'd0);
        chk("sf_rw",    {31'd0, reg_write_o}, 32'd0);
        chk("sf_mw",    {31'd0, mem_write_o}, 32'd0);
        chk("sf_ctrl",  {28'd0, alu_ctrl_o}, 32'd0);
        chk("sf_data1", alu_data1_o, 32'd0);
        stall_i = 1'b0; flush_i = 1'b0;

        // Reload, then async reset mid-cycle during a stall
        drive(32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h10, 4'b0101, 1'b0, 5'd12, 1'b1, 1'b1);
        edge1();
        chk("rl_data1", alu_data1_o, 32'hDEAD_BEEF);
        stall_i = 1'b1;
        #1 rst_i = 1'b1;
        #1;
        chk("ar_data1", alu_data1_o, 32'd0);
        chk("ar_data2", alu_data2_o, 32'd0);
        chk("ar_wdata", mem_wdata_o, 32'd0);
        chk("ar_ctl",   {27'd0, reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o, valid_o}, 32'd0);
        chk("ar_addr",  {17'd0, rs1_addr_o, rs2_addr_o, rd_addr_o}, 32'd0);
        edge1();
        rst_i = 1'b0; stall_i = 1'b0;
        edge1();
        chk("post_valid", {31'd0, valid_o}, 32'd1);
        chk("post_data1", alu_data1_o, 32'hDEAD_BEEF);
        edge1();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline register between instruction decode and the execute-stage ALU of the 5-stage RISC-V core.
- Latches the decoded operands, immediate, register addresses, 4-bit ALU control code and memory/writeback controls at each clock edge.
- Supports stall (hold) and flush (bubble) from the hazard unit.
- On the EX side, applies forwarding muxes and the ALUSrc immediate mux, producing the two signed 32-bit ALU operands and the store data.

Parameters:
- XLEN, 32, datapath width.
- REGW, 5, register address width.
- CTRLW, 4, ALU control code width (codes: AND 0000, XOR 0001, SLL 0010, ADD/ADDI 0011, SUB 0100, MUL 0101, SRAI 0111).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- stall_i  in  1  hold all stage registers.
- flush_i  in  1  load a bubble into the stage.
- rs1_data_i, rs2_data_i  in  XLEN  register file read data from ID.
- imm_i  in  XLEN  sign-extended immediate from ID.
- rs1_addr_i, rs2_addr_i, rd_addr_i  in  REGW  register addresses from ID.
- alu_ctrl_i  in  CTRLW  ALU control from ID.
- alu_src_i  in  1  1 = operand 2 is the immediate.
- reg_write_i, mem_read_i, mem_write_i, mem_to_reg_i  in  1 each  controls from ID.
- forward_a_i, forward_b_i  in  2  forwarding selects: 00 = latched reg, 10 = EX/MEM, 01 = MEM/WB, 11 = latched reg.
- ex_mem_data_i, mem_wb_data_i  in  XLEN  forwarding sources.
- alu_data1_o, alu_data2_o  out  XLEN  ALU operands.
- alu_ctrl_o  out  CTRLW  latched ALU control.
- mem_wdata_o  out  XLEN  store data (forwarded rs2, never the immediate).
- rs1_addr_o, rs2_addr_o, rd_addr_o  out  REGW  latched addresses for the forwarding unit.
- reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o  out  1 each  latched controls.
- valid_o  out  1  stage holds a real instruction.

Behaviour:
- Reset: while rst_i is high, asynchronously clear all stage registers to 0.
  - Resulting outputs: valid_o = 0, all controls 0, alu_ctrl_o = 0000, addresses 0.
  - alu_data1_o and alu_data2_o equal the forwarded sources selected by forward_a_i / forward_b_i with latched values of 0.
- Rising edge, priority order:
  1. flush_i = 1: load a bubble. Controls and valid go to 0, alu_ctrl_o goes to 0000, addresses go to 0. Data registers may load 0 or ID data (don't care); the bench checks them as 0.
  2. Else stall_i = 1: all registers hold their current values.
  3. Else: load every ID input; valid goes to 1.
- Flush has priority over stall when both are high (load-use bubble insertion).
- x0 rule: if rd_addr_i == 0 at load, latch reg_write as 0 regardless of reg_write_i.
- Latency: one cycle from ID inputs to registered outputs.
- EX muxes are combinational on the registered values and the current-cycle forwarding inputs.
  - fwdA = sel(forward_a_i): 10 → ex_mem_data_i, 01 → mem_wb_data_i, otherwise latched rs1.
  - fwdB is formed the same way from forward_b_i and latched rs2.
  - alu_data1_o = fwdA.
  - alu_data2_o = alu_src ? latched imm : fwdB.
  - mem_wdata_o = fwdB.
- Zero-latency path: a change on ex_mem_data_i / mem_wb_data_i propagates to the operands in the same cycle, with no clock needed.
- Data is passed bit-exact, with no sign handling. Signed interpretation happens in the ALU.
- Reset mid-stall or mid-flush: reset wins immediately; no state survives.

Test Plan:
- Reset: assert rst_i asynchronously mid-cycle with live inputs → all outputs 0 within the same cycle, valid_o = 0.
- Normal load: rs1 = 0x00000005, rs2 = 0xFFFFFFFD, alu_ctrl = 0100, alu_src = 0, forwards 00 → after one edge: alu_data1_o = 5, alu_data2_o = 0xFFFFFFFD, alu_ctrl_o = 0100, valid_o = 1.
- ADDI/SRAI immediate path: alu_src = 1, imm = 0x00000002, rs2 = 0x12345678, alu_ctrl = 0111 → alu_data2_o = 2, mem_wdata_o = 0x12345678.
- Forwarding: latched rs1 = 1; forward_a = 10 with ex_mem = 0xAAAA0000 → alu_data1_o = 0xAAAA0000 combinationally. Switch to 01 with mem_wb = 0x0000BBBB → 0x0000BBBB. Switch to 11 → 1.
- Stall/flush: stall 3 cycles while inputs change → outputs frozen. Assert stall and flush together → next edge gives valid_o = 0, reg_write_o = 0, mem_write_o = 0, alu_ctrl_o = 0000.
- x0 write: rd_addr_i = 0, reg_write_i = 1 → reg_write_o = 0. rd_addr_i = 7 → reg_write_o = 1.
